seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
- Reader side of the multiplexed seven-segment display bus: watches the active-low digit enables (an) and the active-low segment bus (seg).
- Reconstructs the 4-bit code shown on each digit, plus its dp state, into registers.
- Used as an on-chip monitor and self-check of the display driver path, and as a readback source for the test bench.
- Input filter: a pattern is accepted only after it has been held stable for a programmable dwell.
- Watchdog: a digit whose readback goes stale loses its valid flag.

Parameters:
- N_DIG, 4: number of multiplexed digits (an width).
- STABLE_CYCLES, 4: consecutive identical samples required to accept a pattern; legal range 2..255.
- STALE_CYCLES, 1000000: cycles without acceptance before a digit's valid bit clears; 0 disables the watchdog; counter width is $clog2(STALE_CYCLES+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- an  in  N_DIG  digit enables, active low; bit i selects digit i
- seg  in  8  segments, active low, {a,b,c,d,e,f,g,dp} with a at bit 7
- digits_o  out  4*N_DIG  decoded code per digit; digit i at [4i+3:4i]
- dp_o  out  N_DIG  decoded dp per digit, 1 = lit
- valid_o  out  N_DIG  digit i holds a fresh accepted reading
- upd_o  out  1  one-cycle pulse on every acceptance
- upd_idx_o  out  $clog2(N_DIG) (min 1)  digit index for the current upd_o
- err_o  out  1  one-cycle pulse, coincident with upd_o, when the accepted pattern is unrecognised

Behaviour:
- Input stage: an and seg are registered once every cycle into r_an and r_seg. All decisions use the registered copies.
- Reset values: digits_o = 4'hE per digit, dp_o = 0, valid_o = 0, upd_o = 0, upd_idx_o = 0, err_o = 0, FSM in IDLE, all counters 0.
- Decode, on seg[7:1] after inversion to active-high:
  - Patterns 0..9 map to codes 0..9.
  - Dash (only g lit) maps to 4'hA.
  - Blank (nothing lit) maps to 4'hE.
  - Any other pattern maps to 4'hF and raises err.
  - dp_o takes ~seg[0].
- FSM states:
  - IDLE: r_an is not exactly one-hot-low (zero or several digits enabled). Stability count held at 0; no acceptance.
  - COUNT: r_an is one-hot-low. cnt counts consecutive cycles in which {r_an, r_seg} equals its previous value. Any difference restarts cnt at 1 and stays in COUNT.
  - HELD: entered at acceptance; remains while {r_an, r_seg} is unchanged, with no repeat acceptance. Any change goes to COUNT (cnt = 1), or to IDLE if the new r_an is not one-hot-low.
- Acceptance (the COUNT-to-HELD transition) happens on the edge where cnt would reach STABLE_CYCLES. On that edge the block:
  - writes digits_o[idx] and dp_o[idx], sets valid_o[idx];
  - pulses upd_o with upd_idx_o = idx;
  - pulses err_o if the code is 4'hF;
  - reloads stale_cnt[idx] to 0.
- Latency: inputs that change just before edge 0 and are then held produce updated outputs and the upd_o pulse after edge STABLE_CYCLES.
- Watchdog (STALE_CYCLES > 0): each digit has its own stale_cnt, which increments every cycle without an acceptance for that digit. When it reaches STALE_CYCLES, valid_o[idx] clears, the counter saturates, and digits_o/dp_o keep their last value.
- Acceptance and watchdog expiry on the same digit in the same cycle: acceptance wins, so valid_o stays 1.
- rst asserted mid-dwell or in HELD: all state returns to reset values on that edge; no upd_o is produced.
- upd_o fires on every acceptance, including when the new value equals the stored one.

Decomposition:
- Shared package seg_pkg holds:
  - 7-bit active-low pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - code constants CODE_DASH = 4'hA, CODE_BLANK = 4'hE, CODE_INV = 4'hF;
  - the segment bit-order definition.
- One combinational sub-module, seg2bin: 8-bit seg in, 4-bit code + dp + err out. It is instanced once on r_seg.

Test Plan:
- Reset, then an=4'b1110 and seg=8'b0010_0101 held 10 cycles, STABLE_CYCLES=4 -> one upd_o after edge 4, upd_idx_o=0, digits_o[3:0]=2, dp_o[0]=0, valid_o=4'b0001, err_o=0.
- Scan digits 0..3 with 1,7,9,dash (seg 8'b1001_1111, 8'b0001_1011, 8'b0001_1001, 8'b1111_1101), 6 cycles each -> digits_o=16'hA971, valid_o=4'b1111, four upd_o pulses with idx 0,1,2,3.
- an=4'b1100 (two digits low), or a one-hot an whose seg toggles every 2 cycles, for 20 cycles -> no upd_o, outputs unchanged.
- an=4'b1011 with seg=8'b0110_0110 (unrecognised), held -> upd_o and err_o pulse together, digits_o[11:8]=4'hF; then seg=8'b0000_0010 -> code 0 with dp_o[2]=1.
- STALE_CYCLES=50: accept digit 1, then an=4'b1111 for 60 cycles -> valid_o[1] falls exactly 50 cycles after acceptance, digits_o[7:4] retained.
- rst pulsed 2 cycles after a new stable pattern starts -> no upd_o, all outputs at reset values; the pattern then held 4 more cycles -> accepted normally.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment readback path: bus bit order,
// active-low glyph patterns, decoded code values and capture FSM encodings.
package seg_pkg;

    // Bit order of the 8-bit segment bus: {a,b,c,d,e,f,g,dp}, a at bit 7
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Active-low patterns on seg[7:1] ({a..g}), 0 = segment lit
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001101;  // a,b,c,f
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;  // a,b,c,f,g
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Alternate glyphs some drivers use for 7 (a,b,c) and 9 (with d lit)
    localparam logic [6:0] SEG_7_ALT = 7'b0001111;
    localparam logic [6:0] SEG_9_ALT = 7'b0000100;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hE;
    localparam logic [3:0] CODE_INV   = 4'hF;

    // Capture FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;

endpackage

// File: rtl/seg2bin.sv
// Combinational decoder from the active-low segment bus to a 4-bit code,
// dp state and an unrecognised-pattern flag.
module seg2bin
    import seg_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] code,
    output logic       dp,
    output logic       err
);

    // Map the seven glyph segments to a code; anything unknown becomes CODE_INV
    always_comb begin
        code = CODE_INV;
        case (seg[SEG_A:SEG_G])
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_7_ALT: code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_9_ALT: code = 4'd9;
            SEG_DASH:  code = CODE_DASH;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INV;
        endcase
        err = (code == CODE_INV);
        dp  = ~seg[SEG_DP];
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Monitor for the multiplexed seven-segment bus: registers an/seg, waits for a
// one-hot digit pattern to stay stable for STABLE_CYCLES samples, then latches
// the decoded code and dp for that digit. A per-digit watchdog drops the valid
// flag when a digit has not been re-accepted for STALE_CYCLES cycles.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int unsigned N_DIG         = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned STALE_CYCLES  = 1000000,
    localparam int unsigned IDX_W        = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_DIG-1:0]     an,
    input  logic [7:0]           seg,
    output logic [4*N_DIG-1:0]   digits_o,
    output logic [N_DIG-1:0]     dp_o,
    output logic [N_DIG-1:0]     valid_o,
    output logic                 upd_o,
    output logic [IDX_W-1:0]     upd_idx_o,
    output logic                 err_o
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [N_DIG-1:0] r_an, last_an;
    logic [7:0]       r_seg, last_seg;
    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [N_DIG-1:0] an_act;
    logic             onehot;
    logic             same;
    logic             accept;
    logic [IDX_W-1:0] idx;

    logic [3:0]       dec_code;
    logic             dec_dp;
    logic             dec_err;

    assign an_act = ~r_an;
    assign onehot = (an_act != '0) && ((an_act & (an_act - N_DIG'(1))) == '0);
    assign same   = ({r_an, r_seg} == {last_an, last_seg});

    // Encode the single enabled digit into an index
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (an_act[i]) idx = IDX_W'(i);
        end
    end

    seg2bin u_seg2bin (
        .seg  (r_seg),
        .code (dec_code),
        .dp   (dec_dp),
        .err  (dec_err)
    );

    // Input sampling plus a one-cycle-older copy for the stability compare
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an     <= '1;
            r_seg    <= '1;
            last_an  <= '1;
            last_seg <= '1;
        end else begin
            r_an     <= an;
            r_seg    <= seg;
            last_an  <= r_an;
            last_seg <= r_seg;
        end
    end

    // Dwell FSM: count identical samples, accept once, then hold until change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (!onehot) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (!same) begin
                        cnt_d = 8'd1;
                    end else if (cnt_q + 8'd1 == STABLE_LIM) begin
                        accept  = 1'b1;
                        state_d = ST_HELD;
                        cnt_d   = cnt_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_HELD: begin
                    if (!same) begin
                        state_d = ST_COUNT;
                        cnt_d   = 8'd1;
                    end
                end
                default: begin
                    // Leaving IDLE always means the pattern just changed
                    state_d = ST_COUNT;
                    cnt_d   = 8'd1;
                end
            endcase
        end
    end

    // FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture registers and the one-cycle update/error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_o  <= {N_DIG{CODE_BLANK}};
            dp_o      <= '0;
            upd_o     <= 1'b0;
            upd_idx_o <= '0;
            err_o     <= 1'b0;
        end else begin
            upd_o <= accept;
            err_o <= accept && dec_err;
            if (accept) begin
                digits_o[4*idx +: 4] <= dec_code;
                dp_o[idx]            <= dec_dp;
                upd_idx_o            <= idx;
            end
        end
    end

    if (STALE_CYCLES > 0) begin : g_wdog
        localparam int unsigned SW = $clog2(STALE_CYCLES + 1);
        localparam logic [SW-1:0] STALE_LIM = SW'(STALE_CYCLES);

        logic [SW-1:0] stale_q [N_DIG];

        // Per-digit staleness: acceptance reloads, expiry clears valid and saturates
        always_ff @(posedge clk) begin
            for (int i = 0; i < N_DIG; i++) begin
                if (rst) begin
                    stale_q[i] <= '0;
                    valid_o[i] <= 1'b0;
                end else if (accept && (idx == IDX_W'(i))) begin
                    stale_q[i] <= '0;
                    valid_o[i] <= 1'b1;
                end else if (stale_q[i] != STALE_LIM) begin
                    stale_q[i] <= stale_q[i] + SW'(1);
                    if (stale_q[i] + SW'(1) == STALE_LIM) valid_o[i] <= 1'b0;
                end
            end
        end
    end else begin : g_nowdog
        // Without a watchdog a digit stays valid once it has been read
        always_ff @(posedge clk) begin
            for (int i = 0; i < N_DIG; i++) begin
                if (rst) begin
                    valid_o[i] <= 1'b0;
                end else if (accept && (idx == IDX_W'(i))) begin
                    valid_o[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: table of single-digit captures plus
// hand-written sequences for scan, filtering, watchdog and reset corners.
module tb_seg_scan_capture;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;
    localparam int STALE  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits_o;
    logic [3:0]  dp_o;
    logic [3:0]  valid_o;
    logic        upd_o;
    logic [1:0]  upd_idx_o;
    logic        err_o;

    seg_scan_capture #(
        .N_DIG         (NDIG),
        .STABLE_CYCLES (STABLE),
        .STALE_CYCLES  (STALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .an        (an),
        .seg       (seg),
        .digits_o  (digits_o),
        .dp_o      (dp_o),
        .valid_o   (valid_o),
        .upd_o     (upd_o),
        .upd_idx_o (upd_idx_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    int n_cmp     = 0;
    int n_fail    = 0;
    int edge_n    = 0;
    int stray_err = 0;

    typedef struct {
        int   edge_at;
        int   idx;
        logic err;
    } upd_rec_t;

    upd_rec_t log_q[$];

    typedef struct {
        int         dig;
        logic [3:0] an;
        logic [7:0] seg;
        logic [3:0] code;
        logic       dp;
        logic       err;
    } vec_t;

    vec_t tbl[13];

    always @(posedge clk) edge_n <= edge_n + 1;

    // Record every update pulse with the edge that produced it
    always @(negedge clk) begin
        if (upd_o === 1'b1) log_q.push_back('{edge_at: edge_n, idx: int'(upd_idx_o), err: err_o});
        if (err_o === 1'b1 && upd_o !== 1'b1) stray_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        step(n);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_digits"}, 32'(digits_o), 32'hEEEE);
        chk({tag, "_dp"}, 32'(dp_o), 32'h0);
        chk({tag, "_valid"}, 32'(valid_o), 32'h0);
        chk({tag, "_upd"}, 32'(upd_o), 32'h0);
        chk({tag, "_idx"}, 32'(upd_idx_o), 32'h0);
        chk({tag, "_err"}, 32'(err_o), 32'h0);
    endtask

    initial begin
        int         e0;
        int         acc;
        int         fall;
        int         drop;
        int         rst_edge;
        logic [3:0] scan_an  [4];
        logic [7:0] scan_seg [4];

        tbl[0]  = '{0, 4'b1110, 8'b0000_0011, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{1, 4'b1101, 8'b1001_1000, 4'h4, 1'b1, 1'b0};
        tbl[2]  = '{2, 4'b1011, 8'b0100_1001, 4'h5, 1'b0, 1'b0};
        tbl[3]  = '{3, 4'b0111, 8'b0100_0001, 4'h6, 1'b0, 1'b0};
        tbl[4]  = '{0, 4'b1110, 8'b0000_0000, 4'h8, 1'b1, 1'b0};
        tbl[5]  = '{1, 4'b1101, 8'b0000_1101, 4'h3, 1'b0, 1'b0};
        tbl[6]  = '{2, 4'b1011, 8'b1111_1111, 4'hE, 1'b0, 1'b0};
        tbl[7]  = '{3, 4'b0111, 8'b1111_1101, 4'hA, 1'b0, 1'b0};
        tbl[8]  = '{0, 4'b1110, 8'b0001_1111, 4'h7, 1'b0, 1'b0};
        tbl[9]  = '{1, 4'b1101, 8'b0000_1001, 4'h9, 1'b0, 1'b0};
        tbl[10] = '{2, 4'b1011, 8'b0111_1111, 4'hF, 1'b0, 1'b1};
        tbl[11] = '{2, 4'b1011, 8'b0111_1111, 4'hF, 1'b0, 1'b1};
        tbl[12] = '{3, 4'b0111, 8'b0010_0101, 4'h2, 1'b0, 1'b0};

        scan_an[0] = 4'b1110; scan_seg[0] = 8'b1001_1111;
        scan_an[1] = 4'b1101; scan_seg[1] = 8'b0001_1011;
        scan_an[2] = 4'b1011; scan_seg[2] = 8'b0001_1001;
        scan_an[3] = 4'b0111; scan_seg[3] = 8'b1111_1101;

        rst = 1'b1;
        an  = 4'b1111;
        seg = 8'hFF;
        @(posedge clk);
        step(2);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Single digit 2 on digit 0, accepted STABLE edges after it appears
        log_q.delete();
        e0 = edge_n + 1;
        hold(4'b1110, 8'b0010_0101, 10);
        chk("t1_upd_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) begin
            chk("t1_upd_edge", 32'(log_q[0].edge_at), 32'(e0 + STABLE));
            chk("t1_upd_idx", 32'(log_q[0].idx), 32'd0);
            chk("t1_err", 32'(log_q[0].err), 32'd0);
        end
        chk("t1_digit0", 32'(digits_o[3:0]), 32'h2);
        chk("t1_dp0", 32'(dp_o[0]), 32'h0);
        chk("t1_valid", 32'(valid_o), 32'b0001);

        // Scan of four digits
        log_q.delete();
        for (int k = 0; k < 4; k++) hold(scan_an[k], scan_seg[k], 6);
        chk("scan_upd_count", 32'(log_q.size()), 32'd4);
        for (int k = 0; k < log_q.size(); k++) chk("scan_upd_idx", 32'(log_q[k].idx), 32'(k));
        chk("scan_digits", 32'(digits_o), 32'hA971);
        chk("scan_valid", 32'(valid_o), 32'b1111);
        chk("scan_dp", 32'(dp_o), 32'h0);

        // Two digits enabled, then a one-hot pattern toggling too fast
        log_q.delete();
        hold(4'b1100, 8'b1001_1111, 20);
        for (int k = 0; k < 5; k++) begin
            hold(4'b1110, 8'b0000_0011, 2);
            hold(4'b1110, 8'b0000_1101, 2);
        end
        chk("filter_no_upd", 32'(log_q.size()), 32'd0);
        chk("filter_digits", 32'(digits_o), 32'hA971);
        chk("filter_dp", 32'(dp_o), 32'h0);

        // Unrecognised pattern, then code 0 with dp lit on digit 2
        log_q.delete();
        e0 = edge_n + 1;
        hold(4'b1011, 8'b0110_0110, 6);
        chk("inv_upd_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) begin
            chk("inv_upd_edge", 32'(log_q[0].edge_at), 32'(e0 + STABLE));
            chk("inv_upd_idx", 32'(log_q[0].idx), 32'd2);
            chk("inv_err", 32'(log_q[0].err), 32'd1);
        end
        chk("inv_digit2", 32'(digits_o[11:8]), 32'hF);
        log_q.delete();
        hold(4'b1011, 8'b0000_0010, 6);
        chk("zero_upd_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) chk("zero_err", 32'(log_q[0].err), 32'd0);
        chk("zero_digit2", 32'(digits_o[11:8]), 32'h0);
        chk("zero_dp2", 32'(dp_o[2]), 32'h1);

        // Table of single-digit captures, each separated by an all-off gap
        pulse_rst();
        for (int v = 0; v < 13; v++) begin
            hold(4'b1111, 8'hFF, 1);
            log_q.delete();
            e0 = edge_n + 1;
            hold(tbl[v].an, tbl[v].seg, 6);
            chk("tbl_upd_count", 32'(log_q.size()), 32'd1);
            if (log_q.size() >= 1) begin
                chk("tbl_upd_edge", 32'(log_q[0].edge_at), 32'(e0 + STABLE));
                chk("tbl_upd_idx", 32'(log_q[0].idx), 32'(tbl[v].dig));
                chk("tbl_err", 32'(log_q[0].err), 32'(tbl[v].err));
            end
            chk("tbl_code", 32'(digits_o[4*tbl[v].dig +: 4]), 32'(tbl[v].code));
            chk("tbl_dp", 32'(dp_o[tbl[v].dig]), 32'(tbl[v].dp));
            chk("tbl_valid", 32'(valid_o[tbl[v].dig]), 32'd1);
        end

        // Watchdog: valid[1] falls STALE edges after acceptance, code retained
        pulse_rst();
        log_q.delete();
        e0 = edge_n + 1;
        hold(4'b1101, 8'b0000_1101, 6);
        acc = (log_q.size() >= 1) ? log_q[0].edge_at : e0 + STABLE;
        chk("stale_upd_edge", 32'(acc), 32'(e0 + STABLE));
        an   = 4'b1111;
        seg  = 8'hFF;
        fall = -1;
        for (int k = 0; k < 60; k++) begin
            step(1);
            if (fall < 0 && valid_o[1] !== 1'b1) fall = edge_n;
        end
        chk("stale_fall_edge", 32'(fall), 32'(acc + STALE));
        chk("stale_digit1", 32'(digits_o[7:4]), 32'h3);
        chk("stale_valid", 32'(valid_o), 32'h0);

        // Re-acceptance on the same edge the watchdog would expire
        pulse_rst();
        log_q.delete();
        e0 = edge_n + 1;
        hold(4'b1101, 8'b0000_1101, 6);
        acc  = e0 + STABLE;
        an   = 4'b1111;
        seg  = 8'hFF;
        drop = 0;
        while (edge_n < acc + STALE - STABLE - 1) begin
            step(1);
            if (valid_o[1] !== 1'b1) drop++;
        end
        an  = 4'b1101;
        seg = 8'b0000_1101;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (valid_o[1] !== 1'b1) drop++;
        end
        chk("collide_valid_drops", 32'(drop), 32'd0);
        chk("collide_upd_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() >= 2) chk("collide_upd_edge", 32'(log_q[1].edge_at), 32'(acc + STALE));

        // Reset two cycles into a new dwell, then the pattern is accepted afresh
        log_q.delete();
        hold(4'b0111, 8'b0100_1001, 2);
        rst = 1'b1;
        step(1);
        rst_edge = edge_n;
        rst = 1'b0;
        chk_reset_outputs("mid_rst");
        chk("mid_rst_no_upd", 32'(log_q.size()), 32'd0);
        step(7);
        chk("post_rst_upd_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) begin
            chk("post_rst_upd_edge", 32'(log_q[0].edge_at), 32'(rst_edge + 1 + STABLE));
            chk("post_rst_upd_idx", 32'(log_q[0].idx), 32'd3);
        end
        chk("post_rst_digits", 32'(digits_o), 32'h5EEE);
        chk("post_rst_valid", 32'(valid_o), 32'b1000);

        chk("err_without_upd", 32'(stray_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
